shift_add_datapath: RTL and testbench
=====================================

// Module: shift_add_datapath
// PURPOSE
//  Datapath for the sequential shift-and-add unsigned multiplier. Consumes Init/LoadA/Shift/End
//  from the multiplier controller and returns DoneShift to it. One iteration per multiplier bit:
//  conditional add on LoadA, one right shift on Shift, then a DoneShift pulse. After WIDTH
//  iterations, End freezes the 2*WIDTH-bit product and raises Valid.
// PARAMETERS
//  WIDTH  16  operand width in bits; 2..62 (controller iteration counter is 6 bits)
// PORTS
//  CLK       in   1        clock; all state updates on rising edge
//  Reset_n   in   1        asynchronous, active-low reset
//  Init      in   1        controller: load operands, clear accumulator
//  LoadA     in   1        controller: conditional add step
//  Shift     in   1        controller: shift step; may stay high for several cycles
//  End       in   1        controller: iterations finished
//  MultA     in   WIDTH    multiplicand, sampled only when Init=1
//  MultB     in   WIDTH    multiplier, sampled only when Init=1
//  DoneShift out  1        one-cycle pulse: shift for this iteration completed
//  Product   out  2*WIDTH  {Acc, Q}; final result once Valid=1
//  Valid     out  1        product final; held until next Init or reset
//  ProtoErr  out  1        sticky: illegal command sequence seen
// BEHAVIOUR
//  Registers: M[WIDTH] multiplicand, Acc[WIDTH], Q[WIDTH] (multiplier/low product), C carry,
//   step FSM {IDLE, ARMED, SHIFTED}.
//  Reset (Reset_n=0, async): M, Acc, Q, C = 0; FSM=IDLE; DoneShift=0; Valid=0; ProtoErr=0.
//  Command priority per edge: Init > End > LoadA > Shift.
//  Init=1: M<=MultA; Q<=MultB; Acc<=0; C<=0; FSM<=IDLE; Valid<=0; ProtoErr<=0; DoneShift<=0.
//   Init mid-operation aborts the running multiply cleanly; no partial state survives.
//  LoadA=1 in IDLE or SHIFTED: if Q[0]=1 then {C,Acc}<=Acc+M (WIDTH+1-bit sum), else C<=0, Acc
//   unchanged; FSM<=ARMED. LoadA in ARMED: no add, FSM unchanged, ProtoErr<=1.
//  Shift=1 in ARMED: {C,Acc,Q}<={1'b0,C,Acc,Q[WIDTH-1:1]} (logical right shift of 2W+1 bits);
//   FSM<=SHIFTED; DoneShift<=1 on this same edge (visible the following cycle, exactly 1 cycle).
//  Shift=1 in IDLE or SHIFTED: ignored, no shift, no DoneShift, no error (controller legally
//   holds Shift high for the cycle in which DoneShift is being returned).
//  DoneShift: registered; high exactly one cycle per accepted shift; 0 in every other cycle.
//  LoadA and Shift both high: LoadA wins; treated as LoadA, ProtoErr<=1.
//  End=1: Valid<=1; FSM<=IDLE; Acc/Q frozen; later LoadA/Shift ignored until Init (no error).
//   End while FSM=ARMED (add done, shift missing): Valid<=1 anyway, ProtoErr<=1.
//  Product = {Acc,Q} combinationally from registers; meaningful only while Valid=1.
//  Arithmetic unsigned; carry from add never lost (shifted into Acc MSB); no overflow possible:
//   (2^W-1)^2 fits in 2W bits.
//  Iteration timing with controller: LoadA(t) -> Shift(t+1) -> DoneShift(t+2) -> LoadA(t+3);
//   3 cycles per bit, 3*WIDTH cycles from first LoadA to last DoneShift.
//  Reset asserted mid-operation: all state to reset values immediately; resumes only after Init.
// TESTING
//  1 Reset then Init MultA=3, MultB=5, drive 16 legal iterations + End -> Product=32'h0000000F, Valid=1, ProtoErr=0.
//  2 MultA=16'hFFFF, MultB=16'hFFFF full run -> Product=32'hFFFE0001 (carry path exercised every bit).
//  3 MultA=16'h1234, MultB=0 -> Acc never changes, Product=0; MultA=0, MultB=16'hABCD -> Product=0.
//  4 Shift held high 3 cycles after one LoadA -> exactly one shift, DoneShift high 1 cycle only.
//  5 LoadA twice without Shift -> single add, ProtoErr=1; LoadA&Shift same cycle -> add only, ProtoErr=1.
//  6 Reset_n low at iteration 7 -> outputs 0 same cycle; Init mid-run (iteration 9) with 7x9 -> Product=63.

Source files
------------

// File: rtl/shift_add_datapath.sv
// Shift-and-add multiplier datapath: one add/shift iteration per multiplier bit, driven by the controller.
// DoneShift is registered one cycle after an accepted shift; no backpressure, commands are applied on the edge they appear.
module shift_add_datapath #(
    parameter int WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 Reset_n,
    input  logic                 Init,
    input  logic                 LoadA,
    input  logic                 Shift,
    input  logic                 End,
    input  logic [WIDTH-1:0]     MultA,
    input  logic [WIDTH-1:0]     MultB,
    output logic                 DoneShift,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Valid,
    output logic                 ProtoErr
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_SHIFTED = 2'd2;

    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mq_q;
    logic             c_q;
    logic [1:0]       state_q;
    logic             done_shift_q;
    logic             valid_q;
    logic             proto_err_q;

    logic [WIDTH:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, m_q};

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            m_q          <= '0;
            acc_q        <= '0;
            mq_q         <= '0;
            c_q          <= 1'b0;
            state_q      <= ST_IDLE;
            done_shift_q <= 1'b0;
            valid_q      <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            done_shift_q <= 1'b0;
            if (Init) begin
                m_q         <= MultA;
                mq_q        <= MultB;
                acc_q       <= '0;
                c_q         <= 1'b0;
                state_q     <= ST_IDLE;
                valid_q     <= 1'b0;
                proto_err_q <= 1'b0;
            end else if (End) begin
                valid_q <= 1'b1;
                state_q <= ST_IDLE;
                if (state_q == ST_ARMED) begin
                    proto_err_q <= 1'b1;
                end
            end else if (valid_q) begin
                // Result frozen: stray LoadA/Shift are dropped until the next Init.
                state_q <= state_q;
            end else if (LoadA) begin
                if (state_q == ST_ARMED) begin
                    proto_err_q <= 1'b1;
                end else begin
                    if (mq_q[0]) begin
                        {c_q, acc_q} <= sum;
                    end else begin
                        c_q <= 1'b0;
                    end
                    state_q <= ST_ARMED;
                    if (Shift) begin
                        proto_err_q <= 1'b1;
                    end
                end
            end else if (Shift && (state_q == ST_ARMED)) begin
                // Carry drops into the accumulator MSB so no add result is lost.
                {c_q, acc_q, mq_q} <= {1'b0, c_q, acc_q, mq_q[WIDTH-1:1]};
                state_q      <= ST_SHIFTED;
                done_shift_q <= 1'b1;
            end
        end
    end

    assign Product   = {acc_q, mq_q};
    assign DoneShift = done_shift_q;
    assign Valid     = valid_q;
    assign ProtoErr  = proto_err_q;

endmodule

// File: tb/tb_shift_add_datapath.sv
// Directed bench for shift_add_datapath: scripted controller, expected products queued at Init.
module tb_shift_add_datapath;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        Init, LoadA, Shift, End;
    logic [15:0] MultA, MultB;
    logic        DoneShift, Valid, ProtoErr;
    logic [31:0] Product;

    int checks = 0;
    int errors = 0;
    int done_cnt;
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;

    shift_add_datapath #(.WIDTH(16)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Init(Init), .LoadA(LoadA), .Shift(Shift), .End(End),
        .MultA(MultA), .MultB(MultB), .DoneShift(DoneShift), .Product(Product),
        .Valid(Valid), .ProtoErr(ProtoErr)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_init(input logic [15:0] a, input logic [15:0] b);
        Init = 1'b1; MultA = a; MultB = b;
        tick;
        Init = 1'b0;
    endtask

    // One legal iteration: LoadA, Shift, then the DoneShift cycle.
    task automatic iter;
        LoadA = 1'b1;
        tick;
        LoadA = 1'b0; Shift = 1'b1;
        tick;
        Shift = 1'b0;
        if (DoneShift === 1'b1) done_cnt++;
        tick;
    endtask

    task automatic finish_run(input string tag);
        logic [31:0] exp;
        int n;
        End = 1'b1;
        tick;
        End = 1'b0;
        n = 0;
        while (Valid !== 1'b1 && n < 8) begin
            tick;
            n++;
        end
        chk({tag, "_valid"}, Valid, 1);
        exp = exp_q.pop_front();
        chk({tag, "_product"}, Product, exp);
        chk({tag, "_protoerr"}, ProtoErr, 0);
    endtask

    task automatic run_mult(input string tag, input logic [15:0] a, input logic [15:0] b);
        do_init(a, b);
        exp_q.push_back({16'd0, a} * {16'd0, b});
        done_cnt = 0;
        repeat (16) iter;
        chk({tag, "_donecnt"}, done_cnt, 16);
        finish_run(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic d1, d2, d3;
        Reset_n = 1'b0; Init = 0; LoadA = 0; Shift = 0; End = 0; MultA = 0; MultB = 0;
        repeat (2) tick;
        chk("rst_product", Product, 0);
        chk("rst_valid", Valid, 0);
        chk("rst_done", DoneShift, 0);
        chk("rst_protoerr", ProtoErr, 0);
        Reset_n = 1'b1;
        tick;

        run_mult("3x5", 16'd3, 16'd5);
        run_mult("ffffxffff", 16'hFFFF, 16'hFFFF);
        run_mult("1234x0", 16'h1234, 16'h0000);
        run_mult("0xabcd", 16'h0000, 16'hABCD);

        // Shift held three cycles: exactly one shift, one DoneShift pulse.
        do_init(16'd3, 16'd5);
        exp_q.push_back(32'd15);
        LoadA = 1'b1; tick; LoadA = 1'b0;
        Shift = 1'b1;
        tick; d1 = DoneShift;
        tick; d2 = DoneShift;
        tick; d3 = DoneShift;
        Shift = 1'b0;
        chk("hold_pulse", {d1, d2, d3}, 3'b100);
        chk("hold_oneshift", Product, 32'h0001_8002);
        done_cnt = 0;
        repeat (15) iter;
        chk("hold_donecnt", done_cnt, 15);
        finish_run("hold");

        // Double LoadA: one add, error flagged; Init clears the error.
        do_init(16'd3, 16'd1);
        LoadA = 1'b1; tick; tick; LoadA = 1'b0;
        chk("dbl_load_product", Product, 32'h0003_0001);
        chk("dbl_load_err", ProtoErr, 1);
        do_init(16'd3, 16'd1);
        chk("init_clears_err", ProtoErr, 0);
        LoadA = 1'b1; Shift = 1'b1; tick; LoadA = 1'b0; Shift = 1'b0;
        chk("ld_sh_product", Product, 32'h0003_0001);
        chk("ld_sh_err", ProtoErr, 1);
        chk("ld_sh_done", DoneShift, 0);

        // End while armed still finalises, flags error, then freezes.
        do_init(16'd2, 16'd1);
        LoadA = 1'b1; tick; LoadA = 1'b0;
        End = 1'b1; tick; End = 1'b0;
        chk("end_armed_valid", Valid, 1);
        chk("end_armed_err", ProtoErr, 1);
        LoadA = 1'b1; tick; LoadA = 1'b0;
        Shift = 1'b1; tick; Shift = 1'b0;
        chk("frozen_product", Product, 32'h0002_0001);
        chk("frozen_done", DoneShift, 0);

        // Async reset mid-run at iteration 7.
        do_init(16'd3, 16'd5);
        repeat (6) iter;
        LoadA = 1'b1; tick; LoadA = 1'b0;
        Reset_n = 1'b0;
        #1;
        chk("midrst_product", Product, 0);
        chk("midrst_valid", Valid, 0);
        chk("midrst_done", DoneShift, 0);
        tick;
        Reset_n = 1'b1;
        tick;

        // Init aborting a run at iteration 9.
        do_init(16'd3, 16'd5);
        repeat (8) iter;
        LoadA = 1'b1; tick; LoadA = 1'b0;
        run_mult("abort7x9", 16'd7, 16'd9);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
